// File: rtl/fetch_arb_pkg.sv
// Shared types and helpers for the fetch-entry arbiter: FSM state, index width, round-robin pick.
package fetch_arb_pkg;

  typedef enum logic [0:0] {ARB, LOCKED} arb_state_e;

  localparam int unsigned MaxNumReq = 4;

  function automatic int unsigned arb_idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First valid index after ptr in ascending modular order; returns ptr when nothing is valid.
  function automatic logic [1:0] rr_pick(logic [MaxNumReq-1:0] valid, logic [1:0] ptr,
                                         int unsigned n);
    logic [1:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= int'(n); i++) begin
      idx = (int'(ptr) + i) % int'(n);
      if (!found && valid[idx]) begin
        pick  = 2'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fetch_entry_arbiter_if.sv
// Requester/ID-stage handshake bundle for fetch_entry_arbiter.
interface fetch_entry_arbiter_if
  import fetch_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned IdxW = arb_idx_w(NumReq);

  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_lock_i;
  logic [NumReq*DataWidth-1:0] req_data_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [DataWidth-1:0]        entry_o;
  logic                        entry_valid_o;
  logic [IdxW-1:0]             entry_id_o;
  logic                        entry_ready_i;
  logic [NumReq*32-1:0]        perf_grant_cnt_o;

  modport slave (
    input  req_valid_i, req_lock_i, req_data_i, entry_ready_i,
    output req_ready_o, entry_o, entry_valid_o, entry_id_o, perf_grant_cnt_o
  );

  modport master (
    output req_valid_i, req_lock_i, req_data_i, entry_ready_i,
    input  req_ready_o, entry_o, entry_valid_o, entry_id_o, perf_grant_cnt_o
  );

endinterface

// File: rtl/fetch_arb_rr_picker.sv
// Combinational modular priority search: first valid requester after ptr_i.
module fetch_arb_rr_picker
  import fetch_arb_pkg::*;
#(
  parameter int unsigned NumReq = 2
) (
  input  logic [NumReq-1:0]              valid_i,
  input  logic [arb_idx_w(NumReq)-1:0]   ptr_i,
  output logic [arb_idx_w(NumReq)-1:0]   idx_o,
  output logic                           found_o
);
  localparam int unsigned IdxW = arb_idx_w(NumReq);

  logic [MaxNumReq-1:0] valid_ext;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NumReq-1:0]  = valid_i;
    idx_o                  = IdxW'(rr_pick(valid_ext, 2'(ptr_i), NumReq));
    found_o                = |valid_i;
  end

endmodule

// File: rtl/fetch_entry_arbiter.sv
// Round-robin fetch-entry arbiter with burst limit, per-requester lock and a registered output.
// Optional per-requester grant counters enabled by defining FETCH_ENTRY_ARB_PERF_EN.
module fetch_entry_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxBurst  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  fetch_entry_arbiter_if.slave  bus
);
  localparam int unsigned IdxW   = arb_idx_w(NumReq);
  localparam int unsigned BurstW = $clog2(MaxBurst + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MaxBurst);

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BurstW-1:0]    burst_q, burst_d;
  logic [DataWidth-1:0] entry_q, entry_d;
  logic                 entry_valid_q, entry_valid_d;
  logic [IdxW-1:0]      entry_id_q, entry_id_d;

  logic [NumReq-1:0] owner_oh;
  logic              owner_valid, others_valid;
  logic [IdxW-1:0]   rr_idx, winner;
  logic              rr_found, win_valid, space, accept;

  assign owner_oh     = NumReq'(1) << owner_q;
  assign owner_valid  = bus.req_valid_i[owner_q];
  assign others_valid = |(bus.req_valid_i & ~owner_oh);

  // Owner is masked out so an exhausted burst always rotates to someone else.
  fetch_arb_rr_picker #(
    .NumReq (NumReq)
  ) u_picker (
    .valid_i (bus.req_valid_i & ~owner_oh),
    .ptr_i   (rr_ptr_q),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

  always_comb begin
    space     = !entry_valid_q || bus.entry_ready_i;
    winner    = owner_q;
    win_valid = 1'b0;
    if (state_q == LOCKED) begin
      win_valid = owner_valid;
    end else if (owner_valid && ((burst_q < BurstMax) || !others_valid)) begin
      win_valid = 1'b1;
    end else if (rr_found) begin
      winner    = rr_idx;
      win_valid = 1'b1;
    end
    accept          = win_valid && space && !flush_i;
    bus.req_ready_o = accept ? (NumReq'(1) << winner) : '0;
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    burst_d       = burst_q;
    entry_d       = entry_q;
    entry_valid_d = entry_valid_q;
    entry_id_d    = entry_id_q;
    if (flush_i) begin
      state_d       = ARB;
      burst_d       = '0;
      entry_valid_d = 1'b0;
    end else if (accept) begin
      entry_d       = bus.req_data_i[winner*DataWidth +: DataWidth];
      entry_id_d    = winner;
      entry_valid_d = 1'b1;
      if (state_q == LOCKED) begin
        if (!bus.req_lock_i[winner]) begin
          state_d = ARB;
          burst_d = BurstMax;
        end
      end else begin
        if (winner == owner_q) begin
          burst_d = (burst_q == BurstMax) ? burst_q : burst_q + 1'b1;
        end else begin
          owner_d  = winner;
          rr_ptr_d = winner;
          burst_d  = BurstW'(1);
        end
        if (bus.req_lock_i[winner]) state_d = LOCKED;
      end
    end else if (bus.entry_ready_i) begin
      entry_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ARB;
      owner_q       <= '0;
      rr_ptr_q      <= IdxW'(NumReq - 1);
      burst_q       <= '0;
      entry_q       <= '0;
      entry_valid_q <= 1'b0;
      entry_id_q    <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_q       <= burst_d;
      entry_q       <= entry_d;
      entry_valid_q <= entry_valid_d;
      entry_id_q    <= entry_id_d;
    end
  end

  assign bus.entry_o       = entry_q;
  assign bus.entry_valid_o = entry_valid_q;
  assign bus.entry_id_o    = entry_id_q;

`ifdef FETCH_ENTRY_ARB_PERF_EN
  logic [NumReq-1:0][31:0] perf_q;

  // Counters survive flush; only rst_i clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else begin
      for (int k = 0; k < int'(NumReq); k++) begin
        if (bus.req_ready_o[k]) perf_q[k] <= perf_q[k] + 32'd1;
      end
    end
  end

  assign bus.perf_grant_cnt_o = perf_q;
`else
  assign bus.perf_grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_entry_arbiter.sv
// Randomized and directed bench for fetch_entry_arbiter against a rule-level reference model.
module tb_fetch_entry_arbiter;
  localparam int unsigned NumReq    = 2;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned MaxBurst  = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  fetch_entry_arbiter_if #(.NumReq(NumReq), .DataWidth(DataWidth)) bus ();

  fetch_entry_arbiter #(
    .NumReq    (NumReq),
    .DataWidth (DataWidth),
    .MaxBurst  (MaxBurst)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit              m_locked;
  int              m_owner, m_ptr, m_burst, m_id;
  bit              m_valid;
  logic [63:0]     m_data;
  int unsigned     m_cnt [NumReq];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_ptr    = NumReq - 1;
    m_burst  = 0;
    m_valid  = 0;
    m_data   = '0;
    m_id     = 0;
    for (int k = 0; k < NumReq; k++) m_cnt[k] = 0;
  endtask

  // Winner by the arbitration rules, -1 when nobody may be granted.
  function automatic int model_winner();
    bit others;
    int k;
    if (m_locked) return bus.req_valid_i[m_owner] ? m_owner : -1;
    others = 0;
    for (int j = 0; j < NumReq; j++) if (j != m_owner && bus.req_valid_i[j]) others = 1;
    if (bus.req_valid_i[m_owner] && (m_burst < MaxBurst || !others)) return m_owner;
    for (int i = 1; i <= NumReq; i++) begin
      k = (m_ptr + i) % NumReq;
      if (k != m_owner && bus.req_valid_i[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [63:0] exp_perf();
    logic [63:0] p;
    p = '0;
`ifdef FETCH_ENTRY_ARB_PERF_EN
    for (int k = 0; k < NumReq; k++) p[k*32 +: 32] = m_cnt[k];
`endif
    return p;
  endfunction

  task automatic drive(input logic [NumReq-1:0] v, input logic [NumReq-1:0] l, input logic rdy,
                       input logic fl);
    bus.req_valid_i   = v;
    bus.req_lock_i    = l;
    bus.entry_ready_i = rdy;
    flush             = fl;
    for (int k = 0; k < NumReq; k++) bus.req_data_i[k*DataWidth +: DataWidth] = {$urandom, $urandom};
  endtask

  task automatic check_outputs();
    check_eq("entry_valid", 64'(bus.entry_valid_o), 64'(m_valid));
    check_eq("entry_id", 64'(bus.entry_id_o), 64'(m_id));
    check_eq("entry", bus.entry_o, m_data);
    check_eq("perf", bus.perf_grant_cnt_o, exp_perf());
  endtask

  // Compare one cycle, then advance DUT and model across the clock edge.
  task automatic cycle();
    int w;
    bit space;
    logic [NumReq-1:0] exp_ready;
    #2;
    w     = model_winner();
    space = !m_valid || bus.entry_ready_i;
    exp_ready = (!flush && space && w >= 0) ? NumReq'(1) << w : '0;
    check_eq("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
    check_outputs();
    @(posedge clk);
    if (flush) begin
      m_valid  = 0;
      m_locked = 0;
      m_burst  = 0;
    end else if (space && w >= 0) begin
      m_data  = bus.req_data_i[w*DataWidth +: DataWidth];
      m_id    = w;
      m_valid = 1;
      m_cnt[w]++;
      if (m_locked) begin
        if (!bus.req_lock_i[w]) begin
          m_locked = 0;
          m_burst  = MaxBurst;
        end
      end else begin
        if (w == m_owner) begin
          if (m_burst < MaxBurst) m_burst++;
        end else begin
          m_owner = w;
          m_burst = 1;
          m_ptr   = w;
        end
        if (bus.req_lock_i[w]) m_locked = 1;
      end
    end else if (bus.entry_ready_i) begin
      m_valid = 0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_eq("reset_ready", 64'(bus.req_ready_o), 64'd0);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All valid: grants r0 x4, r1 x4, r0 ...
    for (int i = 0; i < 12; i++) begin
      drive('1, '0, 1'b1, 1'b0);
      #1;
      check_eq("rr_seq", 64'(bus.req_ready_o), 64'(1 << ((i / 4) % 2)));
      cycle();
    end

    // Lone requester keeps winning past the burst limit.
    for (int i = 0; i < 10; i++) begin
      drive(2'b10, '0, 1'b1, 1'b0);
      #1;
      check_eq("lone_r1", 64'(bus.req_ready_o), 64'd2);
      cycle();
    end

    // Lock sequence on r0 while r1 waits.
    drive(2'b01, 2'b01, 1'b1, 1'b0);
    cycle();
    drive(2'b11, 2'b01, 1'b1, 1'b0);
    cycle();
    drive(2'b10, 2'b00, 1'b1, 1'b0);
    #1;
    check_eq("lock_owner_idle", 64'(bus.req_ready_o), 64'd0);
    cycle();
    drive(2'b11, 2'b00, 1'b1, 1'b0);
    cycle();
    drive(2'b11, 2'b00, 1'b1, 1'b0);
    #1;
    check_eq("post_lock_r1", 64'(bus.req_ready_o), 64'd2);
    cycle();

    // Backpressure for three cycles, then release with a new beat.
    for (int i = 0; i < 4; i++) begin
      drive('1, '0, (i == 3), 1'b0);
      cycle();
    end

    // Flush while locked with an entry held.
    drive(2'b01, 2'b01, 1'b1, 1'b0);
    cycle();
    drive(2'b11, 2'b01, 1'b0, 1'b1);
    cycle();
    drive(2'b10, 2'b00, 1'b1, 1'b0);
    cycle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(NumReq'($urandom), NumReq'($urandom) & NumReq'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
      cycle();
    end

    // Asynchronous reset while locked.
    drive(2'b01, 2'b01, 1'b1, 1'b0);
    cycle();
    bus.req_valid_i = '0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("async_rst_ready", 64'(bus.req_ready_o), 64'd0);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      drive(NumReq'($urandom), '0, 1'b1, 1'b0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_entry_arbiter.md
Name: fetch_entry_arbiter

Overview:
- Shares the single fetch-entry handshake into the decode/issue pipeline register among NumReq instruction sources, e.g. the main frontend, a replay buffer and a debug-ROM injector.
- Sits between the sources and the ID stage, and holds one registered output entry, so the ID stage sees one valid/ready producer.
- Arbitration is round-robin with a bounded burst allowance and a per-requester lock for multi-beat sequences. Flush discards everything held.

Parameters:
- NumReq, 2, number of requesters (2..4).
- DataWidth, 64, width of the opaque packed fetch-entry payload.
- MaxBurst, 4, maximum consecutive grants to one requester while another is waiting (1..15).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard held entry, drop lock, block grants this cycle.
- req_valid_i  in  NumReq  per-requester entry valid.
- req_lock_i  in  NumReq  keep grant on this requester after the current beat.
- req_data_i  in  NumReq*DataWidth  payloads; requester k occupies bits [k*DataWidth +: DataWidth].
- req_ready_o  out  NumReq  one-hot or zero; beat accepted when valid & ready.
- entry_o  out  DataWidth  registered payload to ID stage.
- entry_valid_o  out  1  registered entry valid.
- entry_id_o  out  $clog2(NumReq)  index of requester that produced entry_o.
- entry_ready_i  in  1  ID stage accepts entry this cycle.
- perf_grant_cnt_o  out  NumReq*32  per-requester accepted-beat counters (see Optional Feature).

Behaviour:
- Reset values:
  - entry_valid_o=0, entry_o=0, entry_id_o=0, req_ready_o=0.
  - rr_ptr=NumReq-1, so requester 0 is first.
  - burst_cnt=0, owner=0, state=ARB.
- Space: space = !entry_valid_o || entry_ready_i. There are no grants unless space=1 and flush_i=0. req_ready_o is purely combinational from the request inputs, state and space.
- Latency: a beat accepted in cycle N appears on entry_o/entry_valid_o in cycle N+1. Full throughput is 1 beat/cycle when entry_ready_i is held high.
- State ARB:
  - If owner is valid and burst_cnt<MaxBurst, owner wins.
  - Also, if no other requester is valid, owner wins regardless of burst_cnt.
  - Otherwise the first valid index after rr_ptr, in ascending modular order, wins.
  - On accept:
    - If winner==owner, burst_cnt += 1, saturating at MaxBurst.
    - Otherwise owner=winner, burst_cnt=1, and rr_ptr=winner.
  - If the accepted beat has req_lock_i[winner]=1, state -> LOCKED.
- State LOCKED:
  - Only owner may be granted; other requesters see ready=0 even when owner is idle.
  - burst_cnt is ignored and not incremented.
  - An owner beat accepted with lock=0 returns state -> ARB, with burst_cnt=MaxBurst to force rotation.
- Output register: on accept, load entry_o, entry_id_o and entry_valid_o=1. Otherwise, if entry_ready_i, entry_valid_o=0. Payload and id hold when not loaded.
- Flush (highest priority):
  - Next cycle: entry_valid_o=0, state=ARB, burst_cnt=0.
  - rr_ptr and owner are unchanged.
  - req_ready_o=0 in the flush cycle.
- Simultaneous events: entry_ready_i and a new accept in the same cycle replace the entry with no bubble. A rst_i assertion mid-lock returns to reset values immediately (asynchronous).
- Invariants: req_ready_o is at most one-hot; req_ready_o[k]=1 implies req_valid_i[k]=1.

Optional Feature:
- FETCH_ENTRY_ARB_PERF_EN defined:
  - Per-requester 32-bit counters increment on each accepted beat and wrap at 2^32.
  - They are reset by rst_i only, not by flush.
- Not defined: perf_grant_cnt_o is tied to 0 and no counter flops exist.

Decomposition:
- Shared package fetch_arb_pkg holds:
  - the state enum arb_state_e {ARB, LOCKED};
  - the constant ArbIdxW = $clog2(NumReq) expression helper;
  - a function rr_pick(valid, ptr) returning the winner index.
- One sub-module fetch_arb_rr_picker (combinational modular priority search) is natural. The FSM and registers stay in the top module.

Test Plan:
- Reset then all requesters valid, NumReq=2, MaxBurst=4, entry_ready_i=1 -> grants r0,r0,r0,r0,r1,r1,r1,r1,r0...; entry_id_o follows one cycle later.
- Only r1 valid for 10 cycles -> 10 consecutive r1 grants, with no forced rotation gap.
- r0 beats 1-2 with lock=1, beat 3 with lock=0, r1 valid throughout -> r1 ready=0 until r0 beat 3 accepted; r1 is granted the next cycle.
- entry_ready_i=0 for 3 cycles with entry held -> all req_ready_o=0 and entry_o stable; on the cycle entry_ready_i=1 a new beat loads with no bubble.
- flush_i pulsed while LOCKED with entry_valid_o=1 -> next cycle entry_valid_o=0 and state ARB; r1 becomes grantable and req_ready_o=0 in the flush cycle.
- With FETCH_ENTRY_ARB_PERF_EN: 7 r0 beats and 3 r1 beats -> perf_grant_cnt_o = {3,7}; a flush leaves the counts unchanged; rst_i clears them to 0.
